// File: rtl/led_stream_receiver_if.sv
// Signal bundle between an LED stream source/reader and led_stream_receiver.
// frameChecksum is present only when LED_RX_CHECKSUM_EN is defined.
interface led_stream_receiver_if #(
    parameter int unsigned LEDS = 50
);
    localparam int unsigned AddrW  = $clog2(LEDS);
    localparam int unsigned CountW = $clog2(LEDS + 1);

    logic              ledClock;
    logic              ledData;
    logic [AddrW-1:0]  rdAddr;
    logic [23:0]       rdRGB;
    logic              frameDone;
    logic [CountW-1:0] pixelCount;
    logic              overflow;
    logic              partialError;
    logic              busy;
`ifdef LED_RX_CHECKSUM_EN
    logic [23:0]       frameChecksum;
`endif

    modport master (
        output ledClock, ledData, rdAddr,
        input  rdRGB, frameDone, pixelCount, overflow, partialError, busy
`ifdef LED_RX_CHECKSUM_EN
        , input frameChecksum
`endif
    );

    modport slave (
        input  ledClock, ledData, rdAddr,
        output rdRGB, frameDone, pixelCount, overflow, partialError, busy
`ifdef LED_RX_CHECKSUM_EN
        , output frameChecksum
`endif
    );
endinterface

// File: rtl/led_stream_receiver.sv
// Oversampling WS2801-style clock+data receiver with a double-buffered pixel store.
// Optional frame XOR checksum output enabled by defining LED_RX_CHECKSUM_EN.
module led_stream_receiver #(
    parameter int unsigned LEDS         = 50,
    parameter int unsigned LATCH_CYCLES = 25000,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input logic                 clk,
    input logic                 rst,
    led_stream_receiver_if.slave led_io
);
    localparam int unsigned AddrW  = $clog2(LEDS);
    localparam int unsigned CountW = $clog2(LEDS + 1);
    localparam int unsigned IdleW  = $clog2(LATCH_CYCLES);
    localparam logic [AddrW:0]    LedsA = LEDS;
    localparam logic [CountW-1:0] LedsC = LEDS;

    typedef enum logic [1:0] {StIdle, StRecv, StCommit} state_e;

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s, data_s, rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_prev_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], led_io.ledClock};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], led_io.ledData};
            clk_prev_q  <= clk_s;
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign rise   = clk_s & ~clk_prev_q;

    state_e            state_q;
    logic [23:0]       shift_q;
    logic [4:0]        bit_cnt_q;
    logic [CountW-1:0] pix_idx_q;
    logic [IdleW-1:0]  idle_cnt_q;
    logic              ovf_acc_q;
    logic              pend_q, pend_bit_q;
    logic              bank_q;
    logic              frame_done_q, overflow_q, partial_q, busy_q;
    logic [CountW-1:0] pixel_count_q;
    logic [23:0]       rd_rgb_q;

    // An edge that arrived during the commit cycle is replayed from pend_q.
    logic        edge_v, bit_v, pix_done, idx_full, we;
    logic [23:0] shift_next;

    assign edge_v     = rise | pend_q;
    assign bit_v      = pend_q ? pend_bit_q : data_s;
    assign shift_next = {shift_q[22:0], bit_v};
    assign pix_done   = (state_q == StRecv) && edge_v && (bit_cnt_q == 5'd23);
    assign idx_full   = (pix_idx_q >= LedsC);
    assign we         = pix_done && !idx_full && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            pix_idx_q     <= '0;
            idle_cnt_q    <= '0;
            ovf_acc_q     <= 1'b0;
            pend_q        <= 1'b0;
            pend_bit_q    <= 1'b0;
            bank_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            pixel_count_q <= '0;
            overflow_q    <= 1'b0;
            partial_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (edge_v) begin
                        shift_q    <= shift_next;
                        bit_cnt_q  <= 5'd1;
                        idle_cnt_q <= '0;
                        pend_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StRecv;
                    end
                end
                StRecv: begin
                    if (edge_v) begin
                        shift_q    <= shift_next;
                        idle_cnt_q <= '0;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_q <= '0;
                            if (idx_full) ovf_acc_q <= 1'b1;
                            else          pix_idx_q <= pix_idx_q + 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                        if (idle_cnt_q == IdleW'(LATCH_CYCLES - 2)) state_q <= StCommit;
                    end
                end
                StCommit: begin
                    bank_q        <= ~bank_q;
                    pixel_count_q <= pix_idx_q;
                    overflow_q    <= ovf_acc_q;
                    partial_q     <= (bit_cnt_q != 5'd0);
                    frame_done_q  <= 1'b1;
                    busy_q        <= 1'b0;
                    bit_cnt_q     <= '0;
                    pix_idx_q     <= '0;
                    idle_cnt_q    <= '0;
                    ovf_acc_q     <= 1'b0;
                    state_q       <= StIdle;
                    if (rise) begin
                        pend_q     <= 1'b1;
                        pend_bit_q <= data_s;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // bank_q selects the read bank; the other bank collects the frame in flight.
    logic [23:0] mem0 [LEDS];
    logic [23:0] mem1 [LEDS];

    always_ff @(posedge clk) begin
        if (we && bank_q)  mem0[pix_idx_q[AddrW-1:0]] <= shift_next;
        if (we && !bank_q) mem1[pix_idx_q[AddrW-1:0]] <= shift_next;
    end

    always_ff @(posedge clk) begin
        if (rst)                              rd_rgb_q <= '0;
        else if ({1'b0, led_io.rdAddr} >= LedsA) rd_rgb_q <= '0;
        else if (bank_q)                      rd_rgb_q <= mem1[led_io.rdAddr];
        else                                  rd_rgb_q <= mem0[led_io.rdAddr];
    end

    assign led_io.rdRGB        = rd_rgb_q;
    assign led_io.frameDone    = frame_done_q;
    assign led_io.pixelCount   = pixel_count_q;
    assign led_io.overflow     = overflow_q;
    assign led_io.partialError = partial_q;
    assign led_io.busy         = busy_q;

`ifdef LED_RX_CHECKSUM_EN
    logic [23:0] csum_acc_q, frame_checksum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_acc_q       <= '0;
            frame_checksum_q <= '0;
        end else if (state_q == StCommit) begin
            frame_checksum_q <= csum_acc_q;
            csum_acc_q       <= '0;
        end else if (pix_done) begin
            csum_acc_q <= csum_acc_q ^ shift_next;
        end
    end

    assign led_io.frameChecksum = frame_checksum_q;
`endif
endmodule

// File: doc/led_stream_receiver.md
Name: led_stream_receiver

Overview:
- Receiver for the two-wire, clock-plus-data, WS2801-style LED stream driven onto ledClock/ledData by the LED output driver.
- Oversamples both lines with clk and deserialises 24-bit MSB-first pixels.
- Detects the inter-frame latch gap, then commits the captured frame to a double-buffered pixel store that a host or bench reads by address.
- Used as an on-FPGA loopback checker for the visualiser/LED path, and as a scoreboard front-end in simulation.

Parameters:
- LEDS, 50, maximum pixels stored per frame; extra pixels are dropped.
- LATCH_CYCLES, 25000, idle clk cycles after the last rising ledClock edge that end a frame (500 us at 50 MHz).
- SYNC_STAGES, 2, synchroniser flops on each input line (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ledClock  in  1  serial clock from the LED driver (async to clk).
- ledData  in  1  serial data, valid at the rising edge of ledClock.
- rdAddr  in  $clog2(LEDS)  pixel index into the committed frame.
- rdRGB  out  24  committed pixel at rdAddr, {R,G,B}.
- frameDone  out  1  one-cycle pulse when a frame is committed.
- pixelCount  out  $clog2(LEDS+1)  complete pixels in the committed frame, saturating at LEDS.
- overflow  out  1  committed frame contained more than LEDS pixels.
- partialError  out  1  committed frame ended with 1..23 stray bits.
- busy  out  1  a frame is being received (at least one bit since the last latch).

Behaviour:
- Reset values: frameDone=0, pixelCount=0, overflow=0, partialError=0, busy=0, rdRGB=0, bit counter=0, pixel index=0, idle counter=0, bank select=0.
- Synchronisation:
  - ledClock and ledData each pass through SYNC_STAGES flops.
  - A rising edge is detected when the synced clock is 1 and was 0 on the previous cycle.
  - On that cycle the synced data bit is shifted into a 24-bit register, MSB first.
  - Capture latency from the physical edge is SYNC_STAGES+1 clk cycles.
  - Input high and low phases must each last at least SYNC_STAGES clk cycles; shorter phases are outside the contract.
- States: IDLE, RECV, COMMIT.
  - IDLE: waits for a rising edge; on the first edge capture that bit, go to RECV, set busy=1.
  - RECV, each rising edge:
    - Shift in the bit and increment the bit counter.
    - At 24 bits, write the shift register to writeBank[pixelIdx] if pixelIdx<LEDS, otherwise set an internal overflow flag.
    - Then clear the bit counter and advance pixelIdx, saturating at LEDS.
    - Reset the idle counter to 0.
  - RECV, no edge: increment the idle counter. When it reaches LATCH_CYCLES-1, go to COMMIT.
  - COMMIT (1 cycle):
    - Swap banks, so the read bank becomes the bank just written.
    - Load pixelCount=pixelIdx, overflow, and partialError=(bit counter≠0).
    - Pulse frameDone=1, clear busy and all frame counters, return to IDLE.
    - Stray partial bits are discarded.
- Simultaneous events:
  - A rising edge in the COMMIT cycle is held in the edge-detect register and processed on the next cycle as the first bit of a new frame. No bit is lost.
  - rdAddr may change at any time; rdRGB is registered with a 1-cycle read latency.
  - A read in the swap cycle returns old-bank data; the following cycle returns new-bank data.
- Read range: rdAddr ≥ pixelCount returns stale data from that bank location; rdAddr ≥ LEDS returns 0.
- Frame contents: pixels not written this frame keep prior contents. The bench must respect pixelCount.
- Reset mid-frame discards all state. The committed outputs return to their reset values and stay there until the next complete frame.
- Storage: two LEDS×24 arrays, inferable as RAM, each with one write port and one read port.

Optional Feature:
- Macro LED_RX_CHECKSUM_EN adds output frameChecksum [23:0].
- With the macro defined:
  - frameChecksum is the XOR of every complete 24-bit pixel received in the frame, including overflow pixels.
  - It is loaded in COMMIT alongside pixelCount and is 0 on reset.
- Without the macro, the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then 3 pixels 0xFF0000, 0x00FF00, 0x0000FF at 4 clk per bit, then idle LATCH_CYCLES (bench uses 64) -> one frameDone pulse, pixelCount=3, rdAddr 0/1/2 return those values one cycle later, overflow=0, partialError=0.
- Frame of 52 pixels (pixel k = k) with LEDS=50 -> pixelCount=50, overflow=1, rdAddr 49 returns 0x000031. With LED_RX_CHECKSUM_EN, frameChecksum=XOR(0..51).
- 2 pixels plus 10 extra bits, then latch -> pixelCount=2, partialError=1. The next clean 1-pixel frame 0x123456 gives partialError=0, pixelCount=1.
- Idle gap of LATCH_CYCLES-2 between pixels 1 and 2 -> no frameDone mid-stream, single commit with pixelCount=2.
- rst asserted after 12 bits of a frame -> all outputs 0, no frameDone. A subsequent 1-pixel frame 0xABCDEF commits correctly.
- Hold rdAddr=0 across a commit of 0x111111 after a prior frame of 0x222222 -> rdRGB shows 0x222222 in the swap cycle and 0x111111 from the next cycle.
